// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer and the instruction decoder.
package fetch_unit_pkg;

  // Sequencer states: waiting for the first Start, executing, finished.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

  // PC loaded on Start unless the instance overrides it.
  localparam int DEFAULT_START_ADDR = 0;

  // Instruction word layout: the branch-target LUT index occupies the low bits.
  localparam int INSTR_W        = 9;
  localparam int TARGET_IDX_LSB = 0;
  localparam int TARGET_IDX_W   = 3;

  // Extracts the branch-target LUT index from an instruction word; the decoder
  // and the top level use this so the field position lives in one place.
  function automatic logic [TARGET_IDX_W-1:0] instr_target_idx(input logic [INSTR_W-1:0] instr);
    return instr[TARGET_IDX_LSB +: TARGET_IDX_W];
  endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch offset ROM: LUT_DEPTH signed PC_W-bit offsets, combinational read.
// The offset image is an elaboration-time constant; entry i sits at
// LUT_INIT[i*PC_W +: PC_W].
module fetch_unit_branch_lut #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3,
  parameter int LUT_DEPTH = 2 ** LUT_IDX_W,
  parameter logic [LUT_DEPTH*PC_W-1:0] LUT_INIT = '0
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      offset
);

  logic [PC_W-1:0] lut [LUT_DEPTH];

  // Unpack the flat image into one ROM word per entry.
  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_entry
    assign lut[gi] = LUT_INIT[gi*PC_W +: PC_W];
  end

  assign offset = lut[idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: Start/Done handshake, LUT-relative
// branches, stall/halt handling and a saturating run-cycle counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(DEFAULT_START_ADDR),
  parameter int CNT_W     = 16,
  parameter logic [(2**LUT_IDX_W)*PC_W-1:0] LUT_INIT = '0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] target_idx,
  input  logic                 halt,
  input  logic                 stall,
  output logic [PC_W-1:0]      PC,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_W-1:0]     CycleCount
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;

  logic [PC_W-1:0]  branch_offset;
  logic [PC_W-1:0]  pc_plus_one;
  logic [PC_W-1:0]  pc_branch;
  logic [CNT_W-1:0] cnt_sat_inc;

  fetch_unit_branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W),
    .LUT_INIT  (LUT_INIT)
  ) u_branch_lut (
    .idx    (target_idx),
    .offset (branch_offset)
  );

  // Offsets are PC_W-bit two's complement, so a plain PC_W-bit add wraps both ways.
  assign pc_plus_one = pc_q + PC_W'(1);
  assign pc_branch   = pc_q + branch_offset;
  assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic; branch/halt/stall are only looked at while running,
  // so undriven inputs outside RUN cannot disturb the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FS_IDLE, FS_DONE: begin
        if (Start) begin
          state_d = FS_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      FS_RUN: begin
        if (Start) begin
          // Restart wins over everything, including a simultaneous halt.
          pc_d  = START_ADDR;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_sat_inc;
          if (stall) begin
            pc_d = pc_q;
          end else if (halt) begin
            state_d = FS_DONE;
          end else if (branch_en) begin
            pc_d = pc_branch;
          end else begin
            pc_d = pc_plus_one;
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // State, PC, counter and the decoded status flags, all registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= FS_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == FS_RUN);
      done_q    <= (state_d == FS_DONE);
    end
  end

  assign PC         = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural model of the sequencer rules.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;
  localparam int PC_MOD  = 1024;
  localparam int CNT_MAX = 255;
  localparam int START_I = 64;
  localparam logic [PC_W-1:0] TB_START = 10'h040;
  // Entries 7..0 : +511, -200, +100, 0, -3, +5, -1, +7
  localparam logic [8*PC_W-1:0] TB_LUT =
    {10'h1FF, 10'h338, 10'h064, 10'h000, 10'h3FD, 10'h005, 10'h3FF, 10'h007};

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start, branch_en, halt, stall;
  logic [IDX_W-1:0] target_idx;
  logic [PC_W-1:0]  PC;
  logic             Running, Done;
  logic [CNT_W-1:0] CycleCount;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: signed offsets in plain decimal, state as two flags.
  int tb_off [8] = '{7, -1, 5, -3, 0, 100, -200, 511};
  int m_pc;
  int m_cnt;
  bit m_run;
  bit m_done;

  always #5 Clk = ~Clk;

  fetch_unit #(
    .PC_W       (PC_W),
    .LUT_IDX_W  (IDX_W),
    .START_ADDR (TB_START),
    .CNT_W      (CNT_W),
    .LUT_INIT   (TB_LUT)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .branch_en  (branch_en),
    .target_idx (target_idx),
    .halt       (halt),
    .stall      (stall),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
  endtask

  // Applies the sequencer rules for one clock edge using the driven inputs.
  task automatic model_update();
    if (m_run) begin
      if (Start) begin
        m_pc = START_I; m_cnt = 0;
      end else begin
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (!stall) begin
          if (halt) begin
            m_run = 0; m_done = 1;
          end else if (branch_en) begin
            m_pc = (m_pc + tb_off[target_idx] + PC_MOD) % PC_MOD;
          end else begin
            m_pc = (m_pc + 1) % PC_MOD;
          end
        end
      end
    end else if (Start) begin
      m_pc = START_I; m_cnt = 0; m_run = 1; m_done = 0;
    end
  endtask

  // Drives one cycle of inputs, advances the model, samples 1ns after the edge.
  task automatic cycle(input logic s, input logic b, input logic h, input logic st,
                       input logic [IDX_W-1:0] idx);
    Start = s; branch_en = b; halt = h; stall = st; target_idx = idx;
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1;
    Start = 0; branch_en = 0; halt = 0; stall = 0; target_idx = '0;
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    tests_run++; if (PC !== 10'h000) begin tests_failed++; $display("FAIL reset_pc: got %h expected 000", PC); end
    tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b expected 0", Running); end
    tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", Done); end
    tests_run++; if (CycleCount !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", CycleCount); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    cycle(0, 1, 1, 1, 3'd5);
    cycle(0, 1, 0, 0, 3'd5);
    tests_run++; if (PC !== 10'h000 || Running !== 1'b0) begin tests_failed++; $display("FAIL idle_hold: got pc=%h run=%b expected pc=000 run=0", PC, Running); end
    // Climb to 0x05A: start at 0x040, five +5 branches, one sequential step.
    cycle(1, 0, 0, 0, 3'd0);
    repeat (5) cycle(0, 1, 0, 0, 3'd2);
    cycle(0, 0, 0, 0, 3'd0);
    $display("[TB] reset: running at pc=%h cnt=%0d", PC, CycleCount);
    tests_run++; if (PC !== 10'h05A) begin tests_failed++; $display("FAIL climb_pc: got %h expected 05A", PC); end
    tests_run++; if (CycleCount !== 8'd6) begin tests_failed++; $display("FAIL climb_cnt: got %0d expected 6", CycleCount); end
    // Async reset mid-cycle, checked before the next rising edge.
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    $display("[TB] reset: async assert mid-run -> pc=%h run=%b done=%b cnt=%0d", PC, Running, Done, CycleCount);
    tests_run++; if (PC !== 10'h000) begin tests_failed++; $display("FAIL async_pc: got %h expected 000", PC); end
    tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL async_running: got %b expected 0", Running); end
    tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL async_done: got %b expected 0", Done); end
    tests_run++; if (CycleCount !== 8'd0) begin tests_failed++; $display("FAIL async_cnt: got %0d expected 0", CycleCount); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_sequence();
    cycle(1, 0, 0, 0, 3'd0);
    $display("[TB] sequence: start -> pc=%h run=%b cnt=%0d", PC, Running, CycleCount);
    tests_run++; if (PC !== TB_START || Running !== 1'b1 || Done !== 1'b0) begin tests_failed++; $display("FAIL start_latency: got pc=%h run=%b done=%b expected pc=%h run=1 done=0", PC, Running, Done, TB_START); end
    tests_run++; if (CycleCount !== 8'd0) begin tests_failed++; $display("FAIL start_cnt: got %0d expected 0", CycleCount); end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 3'd0);
      $display("[TB] sequence: step %0d -> pc=%h", i, PC);
      tests_run++; if (PC !== 10'(START_I + i)) begin tests_failed++; $display("FAIL seq_pc%0d: got %h expected %h", i, PC, 10'(START_I + i)); end
    end
    tests_run++; if (CycleCount !== 8'd4 || Running !== 1'b1) begin tests_failed++; $display("FAIL seq_cnt: got cnt=%0d run=%b expected cnt=4 run=1", CycleCount, Running); end
  endtask

  task automatic test_branch();
    cycle(1, 0, 0, 0, 3'd0);
    repeat (16) cycle(0, 1, 0, 0, 3'd3);
    tests_run++; if (PC !== 10'h010) begin tests_failed++; $display("FAIL branch_back: got %h expected 010", PC); end
    cycle(0, 1, 0, 0, 3'd2);
    $display("[TB] branch: +5 from 010 -> pc=%h", PC);
    tests_run++; if (PC !== 10'h015) begin tests_failed++; $display("FAIL branch_fwd: got %h expected 015", PC); end
    repeat (6) cycle(0, 1, 0, 0, 3'd3);
    repeat (2) cycle(0, 1, 0, 0, 3'd1);
    tests_run++; if (PC !== 10'h001) begin tests_failed++; $display("FAIL branch_to1: got %h expected 001", PC); end
    cycle(0, 1, 0, 0, 3'd3);
    $display("[TB] branch: -3 from 001 -> pc=%h", PC);
    tests_run++; if (PC !== 10'h3FE) begin tests_failed++; $display("FAIL branch_wrap: got %h expected 3FE", PC); end
    cycle(0, 1, 0, 0, 3'd4);
    tests_run++; if (PC !== 10'h3FE) begin tests_failed++; $display("FAIL branch_self: got %h expected 3FE", PC); end
  endtask

  task automatic test_wrap_stall();
    cycle(0, 0, 0, 0, 3'd0);
    cycle(0, 0, 0, 0, 3'd0);
    $display("[TB] wrap: 3FF+1 -> pc=%h cnt=%0d", PC, CycleCount);
    tests_run++; if (PC !== 10'h000) begin tests_failed++; $display("FAIL wrap_pc: got %h expected 000", PC); end
    tests_run++; if (CycleCount !== 8'd29) begin tests_failed++; $display("FAIL wrap_cnt: got %0d expected 29", CycleCount); end
    cycle(0, 1, 0, 1, 3'd5);
    $display("[TB] stall: branch ignored -> pc=%h cnt=%0d", PC, CycleCount);
    tests_run++; if (PC !== 10'h000) begin tests_failed++; $display("FAIL stall_pc: got %h expected 000", PC); end
    tests_run++; if (CycleCount !== 8'd30) begin tests_failed++; $display("FAIL stall_cnt: got %0d expected 30", CycleCount); end
    cycle(0, 0, 1, 1, 3'd0);
    tests_run++; if (Running !== 1'b1 || Done !== 1'b0 || PC !== 10'h000) begin tests_failed++; $display("FAIL stall_halt: got run=%b done=%b pc=%h expected run=1 done=0 pc=000", Running, Done, PC); end
  endtask

  task automatic test_halt();
    repeat (4) cycle(0, 1, 0, 0, 3'd0);
    repeat (4) cycle(0, 0, 0, 0, 3'd0);
    tests_run++; if (PC !== 10'h020) begin tests_failed++; $display("FAIL pre_halt_pc: got %h expected 020", PC); end
    cycle(0, 0, 1, 0, 3'd0);
    $display("[TB] halt: pc=%h run=%b done=%b cnt=%0d", PC, Running, Done, CycleCount);
    tests_run++; if (Done !== 1'b1 || Running !== 1'b0) begin tests_failed++; $display("FAIL halt_flags: got done=%b run=%b expected done=1 run=0", Done, Running); end
    tests_run++; if (PC !== 10'h020) begin tests_failed++; $display("FAIL halt_pc: got %h expected 020", PC); end
    repeat (3) cycle(0, 1'bx, 1'bx, 1'bx, 3'bxxx);
    tests_run++; if (PC !== 10'h020 || Done !== 1'b1) begin tests_failed++; $display("FAIL done_hold: got pc=%h done=%b expected pc=020 done=1", PC, Done); end
    tests_run++; if (CycleCount !== 8'd40) begin tests_failed++; $display("FAIL done_cnt: got %0d expected 40", CycleCount); end
    cycle(1, 0, 0, 0, 3'd0);
    $display("[TB] halt: restart -> pc=%h run=%b done=%b", PC, Running, Done);
    tests_run++; if (PC !== TB_START || Done !== 1'b0 || Running !== 1'b1) begin tests_failed++; $display("FAIL restart: got pc=%h done=%b run=%b expected pc=%h done=0 run=1", PC, Done, Running, TB_START); end
    tests_run++; if (CycleCount !== 8'd0) begin tests_failed++; $display("FAIL restart_cnt: got %0d expected 0", CycleCount); end
  endtask

  task automatic test_start_halt();
    repeat (3) cycle(0, 0, 0, 0, 3'd0);
    cycle(1, 0, 1, 0, 3'd0);
    $display("[TB] start+halt: pc=%h run=%b done=%b", PC, Running, Done);
    tests_run++; if (Running !== 1'b1 || Done !== 1'b0 || PC !== TB_START) begin tests_failed++; $display("FAIL start_wins: got run=%b done=%b pc=%h expected run=1 done=0 pc=%h", Running, Done, PC, TB_START); end
    repeat (260) cycle(0, 0, 0, 1, 3'd0);
    tests_run++; if (CycleCount !== 8'd255) begin tests_failed++; $display("FAIL saturate: got %0d expected 255", CycleCount); end
    cycle(0, 0, 0, 1, 3'd0);
    tests_run++; if (CycleCount !== 8'd255 || PC !== TB_START) begin tests_failed++; $display("FAIL sat_hold: got cnt=%0d pc=%h expected cnt=255 pc=%h", CycleCount, PC, TB_START); end
    cycle(1, 0, 1, 0, 3'd0);
    $display("[TB] start+halt at max: cnt=%0d done=%b", CycleCount, Done);
    tests_run++; if (CycleCount !== 8'd0 || Done !== 1'b0) begin tests_failed++; $display("FAIL sat_restart: got cnt=%0d done=%b expected cnt=0 done=0", CycleCount, Done); end
  endtask

  task automatic test_random();
    logic s, b, h, st;
    logic [IDX_W-1:0] idx;
    for (int n = 0; n < 500; n++) begin
      s = ($urandom_range(0, 15) == 0);
      if (m_run) begin
        b   = ($urandom_range(0, 2) == 0);
        h   = ($urandom_range(0, 11) == 0);
        st  = ($urandom_range(0, 3) == 0);
        idx = IDX_W'($urandom_range(0, 7));
      end else begin
        b = 1'bx; h = 1'bx; st = 1'bx; idx = 3'bxxx;
      end
      cycle(s, b, h, st, idx);
      $display("[TB] rnd %0d: s=%b b=%b h=%b st=%b idx=%0d -> pc=%h run=%b done=%b cnt=%0d",
               n, s, b, h, st, idx, PC, Running, Done, CycleCount);
      tests_run++; if (PC !== 10'(m_pc)) begin tests_failed++; $display("FAIL rnd_pc@%0d: got %h expected %h", n, PC, 10'(m_pc)); end
      tests_run++; if (Running !== m_run) begin tests_failed++; $display("FAIL rnd_running@%0d: got %b expected %b", n, Running, m_run); end
      tests_run++; if (Done !== m_done) begin tests_failed++; $display("FAIL rnd_done@%0d: got %b expected %b", n, Done, m_done); end
      tests_run++; if (CycleCount !== 8'(m_cnt)) begin tests_failed++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", n, CycleCount, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_branch();
    test_wrap_stall();
    test_halt();
    test_start_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
